// File: rtl/echo_pkg.sv
// echo_pkg: shared FSM state type and saturation width constants for the echo delay
package echo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_e;
  localparam int SAT_GUARD = 1;
endpackage

// File: rtl/echo_delay_if.sv
// echo_delay_if: sample stream, control and output bundle of the echo delay
interface echo_delay_if #(parameter int A_WIDTH = 9, parameter int D_WIDTH = 8) ();
  import echo_pkg::*;
  logic sample_en, fb_en, flush, dout_valid;
  logic signed [D_WIDTH-1:0] din, dout, mix_out;
  logic [A_WIDTH-1:0] delay;
  state_e state;
  modport master(output sample_en, din, delay, fb_en, flush, input dout, mix_out, dout_valid, state);
  modport slave(input sample_en, din, delay, fb_en, flush, output dout, mix_out, dout_valid, state);
endinterface

// File: rtl/echo_delay_ram.sv
// delay_ram: one write port, one synchronous read port, read returns old contents
module delay_ram #(parameter int A_WIDTH = 9, parameter int D_WIDTH = 8) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);
  logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
  logic [D_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/echo_delay.sv
// echo_delay: circular-buffer echo with fill tracking, saturating feedback and dry/wet mix
module echo_delay #(
  parameter int A_WIDTH  = 9,
  parameter int D_WIDTH  = 8,
  parameter int FB_SHIFT = 1
) (
  input logic clk,
  input logic rst,
  echo_delay_if.slave io
);
  import echo_pkg::*;
  localparam int SW = D_WIDTH + SAT_GUARD;
  localparam logic [A_WIDTH-1:0] FC_MAX = '1;
  typedef logic signed [D_WIDTH-1:0] smp_t;
  logic [A_WIDTH-1:0] wp_q, fc_q, fc_d, wr_addr_q, d_eff, raddr;
  logic [D_WIDTH-1:0] rdata;
  smp_t din_q, fwd_data_q, dout, wdata, fb_term;
  logic fb_q, zero_q, fwd_q, valid_q, wr_pend_q;
  state_e state_q, state_d;
  function automatic smp_t add_sat(input smp_t a, input smp_t b);
    logic [SW-1:0] s;
    s = {a[D_WIDTH-1], a} + {b[D_WIDTH-1], b};
    return (s[SW-1] != s[SW-2]) ? {s[SW-1], {(D_WIDTH-1){~s[SW-1]}}} : s[D_WIDTH-1:0];
  endfunction
  // The write lands one cycle after its strobe so feedback can use the freshly read dout;
  // a back-to-back read of that same address is served from fwd_data_q instead of the RAM.
  always_comb begin
    d_eff = (io.delay == '0) ? A_WIDTH'(1) : io.delay;
    raddr = wp_q - d_eff;
    fc_d = (fc_q == FC_MAX) ? fc_q : fc_q + A_WIDTH'(1);
    dout = zero_q ? '0 : fwd_q ? fwd_data_q : smp_t'(rdata);
    fb_term = dout >>> FB_SHIFT;
    wdata = fb_q ? add_sat(din_q, fb_term) : din_q;
    state_d = (io.flush || !(state_q inside {IDLE, FILL, RUN})) ? IDLE :
              io.sample_en ? ((fc_d == FC_MAX) ? RUN : FILL) : state_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    if (rst || io.flush) begin
      wp_q <= '0;
      fc_q <= '0;
      zero_q <= 1'b1;
      din_q <= '0;
      valid_q <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      valid_q <= io.sample_en;
      wr_pend_q <= io.sample_en;
      if (io.sample_en) begin
        wp_q <= wp_q + A_WIDTH'(1);
        fc_q <= fc_d;
        zero_q <= d_eff > fc_q;
        fwd_q <= wr_pend_q && (raddr == wr_addr_q);
        fwd_data_q <= wdata;
        din_q <= io.din;
        fb_q <= io.fb_en;
        wr_addr_q <= wp_q;
      end
    end
  end
  delay_ram #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_ram (
    .clk(clk), .we_i(wr_pend_q), .waddr_i(wr_addr_q), .wdata_i(wdata),
    .re_i(io.sample_en), .raddr_i(raddr), .rdata_o(rdata)
  );
  assign io.dout = dout;
  assign io.mix_out = add_sat(din_q, dout);
  assign io.dout_valid = valid_q;
  assign io.state = state_q;
endmodule

// File: tb/tb_echo_delay.sv
// tb_echo_delay: table vectors and reference-model sequences checked through an output scoreboard
module tb_echo_delay;
  import echo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  echo_delay_if #(.A_WIDTH(4), .D_WIDTH(8)) bus ();
  echo_delay #(.A_WIDTH(4), .D_WIDTH(8), .FB_SHIFT(1)) dut (.clk(clk), .rst(rst), .io(bus));
  typedef struct { logic signed [7:0] dout; logic signed [7:0] mix; } exp_t;
  typedef struct { bit fl; int gap; int din; int dly; bit fb; int ed; int em; } vec_t;
  exp_t exp_q[$];
  exp_t e;
  int hist[$];
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  function automatic int sat_i(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction
  always @(posedge clk) begin
    #2;
    if (bus.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_dout_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("dout", int'(bus.dout), int'(e.dout));
        check("mix_out", int'(bus.mix_out), int'(e.mix));
      end
    end
  end
  task automatic drive(input int x, input int d, input bit f, input int ed, input int em, input int gap);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.flush = 1'b0;
    bus.din = 8'(x);
    bus.delay = 4'(d);
    bus.fb_en = f;
    exp_q.push_back(exp_t'{8'(ed), 8'(em)});
    if (gap > 0) begin
      @(negedge clk);
      bus.sample_en = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask
  task automatic model(input int x, input int d, input bit f, input int gap);
    int deff, n, y;
    deff = (d == 0) ? 1 : d;
    n = hist.size();
    y = (deff > (n > 15 ? 15 : n)) ? 0 : hist[n - deff];
    hist.push_back(f ? sat_i(x + (y >>> 1)) : x);
    drive(x, d, f, y, sat_i(x + y), gap);
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.flush = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic do_flush(input bit with_sample);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.sample_en = with_sample;
    bus.din = 8'sd55;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.sample_en = 1'b0;
    hist.delete();
  endtask
  task automatic probe(input string tag, input int st);
    check({tag, "_dout"}, int'(bus.dout), 0);
    check({tag, "_mix_out"}, int'(bus.mix_out), 0);
    check({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
    check({tag, "_state"}, int'(bus.state), st);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.sample_en = 1'b0;
    bus.flush = 1'b0;
    bus.din = '0;
    bus.delay = '0;
    bus.fb_en = 1'b0;
    repeat (3) @(negedge clk);
    probe("reset", 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      tbl.push_back(vec_t'{1'b0, 0, i + 1, 3, 1'b0, (i < 3) ? 0 : i - 2, (i < 3) ? i + 1 : 2 * i - 1});
    tbl.push_back(vec_t'{1'b1, 0, 64, 1, 1'b1, 0, 64});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 64, 64});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 32, 32});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 16, 16});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 8, 8});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 4, 4});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 2, 2});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 1, 1});
    tbl.push_back(vec_t'{1'b0, 0, 0, 1, 1'b1, 0, 0});
    tbl.push_back(vec_t'{1'b1, 2, 100, 1, 1'b0, 0, 100});
    tbl.push_back(vec_t'{1'b0, 2, 100, 1, 1'b0, 100, 127});
    tbl.push_back(vec_t'{1'b0, 2, -100, 1, 1'b0, 100, 0});
    tbl.push_back(vec_t'{1'b0, 2, -100, 1, 1'b0, -100, -128});
    tbl.push_back(vec_t'{1'b0, 2, -100, 1, 1'b1, -100, -128});
    tbl.push_back(vec_t'{1'b0, 2, 100, 1, 1'b1, -128, -28});
    tbl.push_back(vec_t'{1'b0, 2, 100, 1, 1'b1, 36, 127});
    tbl.push_back(vec_t'{1'b0, 2, 100, 1, 1'b1, 118, 127});
    tbl.push_back(vec_t'{1'b0, 2, 0, 1, 1'b0, 127, 127});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].fl) begin
        idle(1);
        do_flush(1'b0);
        probe("table_flush", 0);
      end
      drive(tbl[i].din, tbl[i].dly, tbl[i].fb, tbl[i].ed, tbl[i].em, tbl[i].gap);
    end
    idle(2);
    check("state_fill", int'(bus.state), 1);
    do_flush(1'b0);
    for (int i = 0; i < 5; i++) model(10 * (i + 1), 0, 1'b0, 1);
    idle(1);
    do_flush(1'b0);
    for (int i = 0; i < 15; i++) model(i + 1, 15, 1'b0, 0);
    idle(2);
    check("state_run", int'(bus.state), 2);
    model(16, 15, 1'b0, 1);
    model(17, 3, 1'b0, 0);
    model(18, 7, 1'b0, 1);
    model(19, 1, 1'b0, 0);
    model(20, 1, 1'b1, 1);
    idle(1);
    do_flush(1'b1);
    idle(2);
    probe("flush_with_sample", 0);
    for (int i = 0; i < 5; i++) model(7 * i - 20, 3, 1'b1, 1);
    idle(1);
    for (int i = 0; i < 4; i++) model(-(i + 5), 2, 1'b0, 0);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    bus.sample_en = 1'b1;
    bus.din = 8'sd99;
    @(negedge clk);
    rst = 1'b0;
    bus.sample_en = 1'b0;
    hist.delete();
    probe("mid_reset", 0);
    for (int i = 0; i < 3; i++) model(20 * i + 1, 1, 1'b0, 1);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/echo_delay.md
ECHO_DELAY -- requirements
Module: echo_delay

Interface
REQ-001 Parameter A_WIDTH, default 9, address width; DEPTH = 2**A_WIDTH samples.
REQ-002 Parameter D_WIDTH, default 8, sample width, signed two's complement.
REQ-003 Parameter FB_SHIFT, default 1, feedback attenuation as an arithmetic right shift.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sample_en  input  1  one-cycle strobe: din valid, advance delay line.
REQ-007 din  input  D_WIDTH  signed input sample.
REQ-008 delay  input  A_WIDTH  requested delay in samples, sampled on sample_en.
REQ-009 fb_en  input  1  enable echo feedback, sampled on sample_en.
REQ-010 flush  input  1  one-cycle strobe: discard buffered history.
REQ-011 dout  output  D_WIDTH  delayed sample.
REQ-012 mix_out  output  D_WIDTH  saturated din + dout (dry + wet).
REQ-013 dout_valid  output  1  one-cycle strobe: dout/mix_out updated.
REQ-014 state  output  2  current FSM state, for debug.

Function
REQ-015 Write pointer wp SHALL increment by 1 modulo DEPTH on each sample_en; wraps DEPTH-1 -> 0.
REQ-016 Effective delay d_eff SHALL be: delay==0 -> 1; otherwise delay (max DEPTH-1).
REQ-017 On sample_en the RAM SHALL be read at (wp - d_eff) mod DEPTH and written at wp in the same cycle; read returns the old contents (read-before-write).
REQ-018 Latency: dout, mix_out, dout_valid SHALL update exactly 1 cycle after sample_en; dout_valid high for that one cycle only.
REQ-019 Fill counter fc SHALL count samples written since reset/flush, saturating at DEPTH-1.
REQ-020 If d_eff > fc at the read, dout SHALL be 0 (unwritten history is silence).
REQ-021 Written value SHALL be din when fb_en=0, else sat(din + (dout >>> FB_SHIFT)), dout being the current registered output.
REQ-022 sat() SHALL clamp to [-2**(D_WIDTH-1), 2**(D_WIDTH-1)-1]; internal sums use D_WIDTH+1 bits.
REQ-023 mix_out SHALL be sat(din_q + dout), din_q = din registered on the same sample_en.
REQ-024 FSM states: IDLE=0 (fc==0), FILL=1 (0<fc<DEPTH-1), RUN=2 (fc==DEPTH-1); encoding 3 unused, recovers to IDLE.
REQ-025 Transitions: IDLE->FILL on first sample_en; FILL->RUN when fc reaches DEPTH-1; any state->IDLE on flush.
REQ-026 flush SHALL clear wp, fc, dout, mix_out, dout_valid next cycle; RAM contents not cleared.
REQ-027 flush and sample_en in the same cycle: flush wins, sample discarded, no dout_valid.
REQ-028 Changing delay between samples SHALL take effect on the next sample_en with no glitch or extra dout_valid.

Reset
REQ-029 rst SHALL set wp=0, fc=0, dout=0, mix_out=0, dout_valid=0, state=IDLE; RAM not cleared.
REQ-030 rst asserted mid-operation SHALL abort any pending dout_valid and override sample_en and flush.

Structure
REQ-031 Shared package echo_pkg SHALL hold the state enum type and the sat() width helper constants.
REQ-032 Storage SHALL be a sub-module delay_ram: one write port, one synchronous read port, read-before-write, parametrised A_WIDTH/D_WIDTH.
REQ-033 FSM, pointers, fill counter, feedback and saturation logic SHALL reside in echo_delay.

Verification (A_WIDTH=4, D_WIDTH=8, FB_SHIFT=1)
REQ-034 delay=3, fb_en=0, din=1,2,3,... on consecutive sample_en -> dout=0,0,0,1,2,3,...; dout_valid one cycle after each strobe.
REQ-035 delay=0 -> behaves as delay=1: dout lags din by one sample; delay=15 -> first nonzero dout on 16th sample; state RUN after 15 samples.
REQ-036 fb_en=1, delay=1, impulse din=64 then zeros -> dout=0,64,32,16,8,4,2,1,0.
REQ-037 din=100 while dout=100 -> mix_out=127; din=-100, dout=-100 -> mix_out=-128; feedback write likewise saturates.
REQ-038 20 samples written, flush together with sample_en -> no dout_valid, state=IDLE, next samples' dout=0 until refilled.
REQ-039 rst asserted mid-stream with sample_en high -> all outputs 0, state IDLE next cycle, wp restarts at 0.
